// File: rtl/alu_log_replay_checker.sv
// alu_log_replay_checker
//
// Replays a captured snapshot of the operation log into one alu slice and
// checks each recomputed result against the result recorded in the log.
// Entries are walked in order from entry 0. The block reports how many
// entries disagreed and which entry disagreed first.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   start       requests a replay (only honoured while idle)
//   count       number of entries to replay (clamped to DEPTH)
//   log_in      log snapshot, entry k at bits [32k+31:32k]
//               byte0 = in1[3:0], byte1 = in2[3:0], byte2 = op[5:0],
//               byte3 = recorded result
//   alu_a       registered operand a to the ALU
//   alu_b       registered operand b to the ALU
//   alu_s       registered opcode to the ALU
//   alu_d       ALU result, valid ALU_LAT cycles after the operands
//   busy        high whenever a replay is in progress
//   done        one-cycle pulse when a replay completes
//   pass        1 when the last replay found no mismatches
//   mismatches  saturating mismatch count
//   fail_idx    first mismatching entry, 4'hF when none
module alu_log_replay_checker #(
  parameter int DEPTH   = 10,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           count,
  input  logic [DEPTH*32-1:0]  log_in,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [5:0]           alu_s,
  input  logic [7:0]           alu_d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           mismatches,
  output logic [3:0]           fail_idx
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] DEPTH4    = 4'(DEPTH);
  // WAIT covers ALU_LAT-1 cycles, so the countdown starts at ALU_LAT-2.
  localparam logic [2:0] WAIT_INIT = (ALU_LAT > 1) ? 3'(ALU_LAT - 2) : 3'd0;

  state_t               state;
  state_t               state_next;
  logic [DEPTH*32-1:0]  snap;
  logic [3:0]           n_entries;
  logic [3:0]           idx;
  logic [2:0]           wait_cnt;
  logic [3:0]           clamped;
  logic                 last_entry;
  logic [31:0]          cur_word;
  logic [31:0]          load_word;
  logic                 unused_bits;

  // Selects one 32-bit entry from a snapshot; out-of-range selects give 0.
  function automatic logic [31:0] entry_at(input logic [DEPTH*32-1:0] s,
                                           input logic [3:0] sel);
    entry_at = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (sel == 4'(e)) entry_at = s[e*32 +: 32];
    end
  endfunction

  assign clamped    = (count > DEPTH4) ? DEPTH4 : count;
  assign last_entry = (idx == n_entries - 4'd1);
  assign cur_word   = entry_at(snap, idx);
  // In IDLE entry 0 comes straight from the bus, since the snapshot is
  // captured on the same edge; in CHECK the next entry comes from the snapshot.
  assign load_word  = (state == IDLE) ? log_in[31:0] : entry_at(snap, idx + 4'd1);
  // Upper bits of bytes 0..2 are ignored by design.
  assign unused_bits = ^{cur_word[23:0], load_word[31:22], load_word[15:12], load_word[7:4]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (clamped == 4'd0) ? DONE : ISSUE;
      ISSUE:   state_next = (ALU_LAT > 1) ? WAIT : CHECK;
      WAIT:    if (wait_cnt == 3'd0) state_next = CHECK;
      CHECK:   state_next = last_entry ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: snapshot capture, ALU drive, latency countdown and result
  // bookkeeping. The ALU operand registers keep the last driven entry
  // between runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= '0;
      n_entries  <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      pass       <= 1'b0;
      mismatches <= '0;
      fail_idx   <= 4'hF;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap       <= log_in;
            n_entries  <= clamped;
            idx        <= '0;
            pass       <= 1'b0;
            mismatches <= '0;
            fail_idx   <= 4'hF;
            if (clamped != 4'd0) begin
              alu_a <= load_word[3:0];
              alu_b <= load_word[11:8];
              alu_s <= load_word[21:16];
            end
          end
        end
        ISSUE: wait_cnt <= WAIT_INIT;
        WAIT:  if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        CHECK: begin
          if (alu_d != cur_word[31:24]) begin
            if (mismatches != 4'hF) mismatches <= mismatches + 4'd1;
            // The count never wraps back to zero, so zero means first failure.
            if (mismatches == 4'd0) fail_idx <= idx;
          end
          if (!last_entry) begin
            idx   <= idx + 4'd1;
            alu_a <= load_word[3:0];
            alu_b <= load_word[11:8];
            alu_s <= load_word[21:16];
          end
        end
        DONE: pass <= (mismatches == 4'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_log_replay_checker.md
# alu_log_replay_checker

Replays a snapshot of the 10-entry operation log (operands, opcode, recorded result per entry) into one `alu` slice and checks each recomputed result against the logged one. It is the read/consume side of the operation log: the log writer records traffic, and this block walks the entries back in order, drives the ALU, and reports the mismatch count and the first failing entry. It sits beside an `alu` instance in self-test and debug builds.

## Interface
Parameters:
- `DEPTH`, 10, number of log entries in the snapshot bus (1..15).
- `ALU_LAT`, 1, cycles from ALU inputs to a valid `d` (1..7). The `alu` slice's output register gives 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a replay; sampled only in IDLE.
- `count`  in  4  number of entries to replay, from entry 0 up; values above DEPTH are clamped to DEPTH.
- `log_in`  in  DEPTH*32  log snapshot. Entry k occupies bits [32k+31:32k].
  - byte0 = in1; only [3:0] are used.
  - byte1 = in2; only [3:0] are used.
  - byte2 = op; only [5:0] are used.
  - byte3 = recorded result.
- `alu_a`  out  4  operand a to the ALU; registered.
- `alu_b`  out  4  operand b to the ALU; registered.
- `alu_s`  out  6  opcode to the ALU; registered.
- `alu_d`  in  8  ALU result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a replay completes.
- `pass`  out  1  1 when the last replay found zero mismatches.
- `mismatches`  out  4  mismatch count; saturates at 15.
- `fail_idx`  out  4  index of the first mismatching entry; 4'hF when there is none.

## Operation
States: IDLE, ISSUE, WAIT, CHECK, DONE.

- **IDLE**
  - `start`=1 accepts a replay: capture `log_in` and the clamped `count` into internal registers, set index i=0, and clear `mismatches`, `pass` and `fail_idx` (to 0, 0, 4'hF).
  - If the clamped count is 0, go to DONE. Otherwise load entry 0 onto `alu_a`/`alu_b`/`alu_s` and go to ISSUE.
- **ISSUE** (1 cycle)
  - Entry i is presented on the ALU outputs.
  - Go to WAIT if ALU_LAT>1, else go to CHECK.
- **WAIT** (ALU_LAT-1 cycles)
  - Counts down, then goes to CHECK.
- **CHECK** (1 cycle)
  - Compare all 8 bits of `alu_d` with byte3 of entry i.
  - On inequality, increment `mismatches` (saturating). If this is the first mismatch of the run, set `fail_idx`=i.
  - If i is the last entry, go to DONE. Otherwise set i=i+1, load entry i+1 onto the ALU outputs, and go to ISSUE.
- **DONE** (1 cycle)
  - `done`=1.
  - `pass`=1 iff `mismatches`==0.
  - Return to IDLE.

General rules:
- `alu_a`/`alu_b`/`alu_s` hold entry i from ISSUE through CHECK. Between runs they hold the last entry driven.
- Zero-extend the 4-bit operands and 6-bit opcode internally. The unused upper bits of bytes 0–2 are ignored.
- The captured snapshot is used for the whole run. Changes on `log_in` or `count` while busy have no effect.
- `start` outside IDLE is ignored, including in the DONE cycle. It is not queued.
- `pass`, `mismatches` and `fail_idx` hold their values from DONE until the next accepted `start`.

## Timing
- Reset values, applied on the first edge with `reset`=1: state IDLE, `alu_a`=0, `alu_b`=0, `alu_s`=0, `busy`=0, `done`=0, `pass`=0, `mismatches`=0, `fail_idx`=4'hF.
- Reset asserted mid-run aborts the run immediately. No `done` pulse is produced, and all outputs take their reset values.
- Reset has priority over `start` on the same edge.
- With `start` accepted at edge 0, entry j is in ISSUE during cycle 1+j*(ALU_LAT+1), and its CHECK compare completes at the edge ending cycle (j+1)*(ALU_LAT+1).
- With N entries (clamped count), DONE is the cycle immediately after the last CHECK. The `done` pulse is in cycle N*(ALU_LAT+1)+1.
  - Example: N=10, ALU_LAT=1 gives `done` in cycle 21.
- With N=0, `done` is in cycle 1.
- The earliest next `start` is accepted in the IDLE cycle after DONE.

## Test plan
The bench ALU model registers `d` once (ALU_LAT=1). Opcode 6'h01 computes a+b; 6'h00 computes a*b.

- Entries {3,5,01,8}, {4,4,00,16}, {15,15,01,30}, `count`=3, `start` → per-entry drive sequence (3,5,01), (4,4,00), (15,15,01) on the ALU outputs; `done` in cycle 7; `pass`=1, `mismatches`=0, `fail_idx`=F.
- Same entries but entry 1 result logged as 17 → `pass`=0, `mismatches`=1, `fail_idx`=1.
- 10 entries all with wrong results, `count`=12 → count clamped to 10; `mismatches`=10, `fail_idx`=0, `done` in cycle 21.
- `count`=0 with `start` → `done` in cycle 1, `pass`=1, `mismatches`=0, `fail_idx`=F; the ALU outputs are unchanged.
- Pulse `start` again in cycle 4 of a run, and change `log_in` mid-run → both ignored; the results match the originally captured snapshot.
- Assert `reset` in cycle 3 of a 3-entry run → all outputs return to reset values; no `done` pulse; a fresh `start` afterwards completes with the correct results.
